// File: rtl/fadd32_pkg.sv
// Shared types and constants for the fadd32 round-robin scheduler.
package fadd32_pkg;

    // Scheduler FSM states
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    // fadd32 operation select
    localparam logic FADD_MODE_ADD = 1'b0;
    localparam logic FADD_MODE_SUB = 1'b1;

endpackage

// File: rtl/fadd32_rr_sched_if.sv
// Request/response bundle between the compute clients and the shared adder.
// Operand buses are packed, 32 bits per requester, requester i at [32i+31:32i].
interface fadd32_rr_sched_if #(
    parameter int NREQ = 4
);
    logic [NREQ-1:0]    req_valid;
    logic [NREQ-1:0]    req_ready;
    logic [32*NREQ-1:0] req_a;
    logic [32*NREQ-1:0] req_b;
    logic [NREQ-1:0]    req_mode;
    logic [NREQ-1:0]    rsp_valid;
    logic [NREQ-1:0]    rsp_ready;
    logic [31:0]        rsp_res;

    // Client side
    modport master (
        output req_valid, req_a, req_b, req_mode, rsp_ready,
        input  req_ready, rsp_valid, rsp_res
    );

    // Scheduler side
    modport slave (
        input  req_valid, req_a, req_b, req_mode, rsp_ready,
        output req_ready, rsp_valid, rsp_res
    );
endinterface

// File: rtl/fadd32.sv
// Single-precision combinational adder/subtractor, round to nearest even.
// Subnormal inputs and results are flushed to zero; Inf/NaN operands pass through.
module fadd32
    import fadd32_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        mode,
    output logic [31:0] res
);
    logic              sa, sb, sx, sy;
    logic [7:0]        ea, eb, ex, ey, shamt;
    logic [22:0]       fx, fy;
    logic [26:0]       mx, my, my_sh, mask, man;
    logic [27:0]       sum;
    logic [4:0]        lz;
    logic signed [9:0] exp_w;
    logic [24:0]       mant;
    logic              round_up;

    // Align, add/subtract, normalise, round
    always_comb begin
        sa = a[31];
        sb = b[31] ^ (mode == FADD_MODE_SUB);
        ea = a[30:23];
        eb = b[30:23];
        // x is the operand of larger magnitude
        if ({ea, a[22:0]} >= {eb, b[22:0]}) begin
            sx = sa; ex = ea; fx = a[22:0];
            sy = sb; ey = eb; fy = b[22:0];
        end else begin
            sx = sb; ex = eb; fx = b[22:0];
            sy = sa; ey = ea; fy = a[22:0];
        end
        // hidden bit, 23 fraction bits, guard/round/sticky
        mx    = (ex == 8'd0) ? '0 : {1'b1, fx, 3'b000};
        my    = (ey == 8'd0) ? '0 : {1'b1, fy, 3'b000};
        shamt = ex - ey;
        mask  = ~(27'h7ffffff << shamt);
        if (shamt >= 8'd27) begin
            my_sh = {26'd0, |my};
        end else begin
            my_sh = (my >> shamt) | {26'd0, |(my & mask)};
        end
        if (sx == sy) begin
            sum = {1'b0, mx} + {1'b0, my_sh};
        end else begin
            sum = {1'b0, mx} - {1'b0, my_sh};
        end
        exp_w = signed'({2'b00, ex});
        lz    = '0;
        if (sum[27]) begin
            man   = {sum[27:2], sum[1] | sum[0]};
            exp_w = exp_w + 10'sd1;
        end else begin
            man = sum[26:0];
            for (int i = 0; i < 27; i++) begin
                if (man[i]) begin
                    lz = 5'(26 - i);
                end
            end
            man   = man << lz;
            exp_w = exp_w - signed'({5'd0, lz});
        end
        round_up = man[2] & (man[1] | man[0] | man[3]);
        mant     = {1'b0, man[26:3]} + {24'd0, round_up};
        if (mant[24]) begin
            mant  = mant >> 1;
            exp_w = exp_w + 10'sd1;
        end
        if (sum == 28'd0 || exp_w <= 10'sd0 || !mant[23]) begin
            res = {sx & sy, 31'd0};
        end else if (exp_w >= 10'sd255) begin
            res = {sx, 8'hff, 23'd0};
        end else begin
            res = {sx, exp_w[7:0], mant[22:0]};
        end
        if (ea == 8'hff) begin
            res = a;
        end else if (eb == 8'hff) begin
            res = {sb, b[30:0]};
        end
    end
endmodule

// File: rtl/rr_pick.sv
// Combinational round-robin pick: first valid index at or after ptr, wrapping.
module rr_pick #(
    parameter int NREQ  = 4,
    parameter int PTR_W = 2
) (
    input  logic [NREQ-1:0]  valid,
    input  logic [PTR_W-1:0] ptr,
    output logic [PTR_W-1:0] grant,
    output logic             any_valid
);
    localparam logic [PTR_W:0] NREQ_W = (PTR_W + 1)'(NREQ);

    logic [NREQ-1:0]  rot;
    logic [PTR_W-1:0] off;
    logic [PTR_W:0]   sum;

    // Rotate so ptr lands at bit 0, take the lowest set bit, then rotate back
    always_comb begin
        rot       = NREQ'({valid, valid} >> ptr);
        any_valid = |valid;
        off       = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (rot[k]) begin
                off = PTR_W'(k);
            end
        end
        sum = {1'b0, ptr} + {1'b0, off};
        if (sum >= NREQ_W) begin
            sum = sum - NREQ_W;
        end
        grant = sum[PTR_W-1:0];
    end
endmodule

// File: rtl/fadd32_rr_sched.sv
// Shares one fadd32 between NREQ requesters with round-robin grants.
// One operation in flight: accept (IDLE) -> compute (EXEC) -> hold result (RESP).
module fadd32_rr_sched
    import fadd32_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int PTR_W = $clog2(NREQ),
    parameter int CNT_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    fadd32_rr_sched_if.slave  bus,
    output logic              busy,
    output logic [CNT_W-1:0]  op_count
);
    state_t            state_reg, state_next;
    logic [PTR_W-1:0]  ptr_reg, owner_reg, grant, ptr_inc;
    logic              any_valid, accept, take;
    logic [31:0]       a_reg, b_reg, res_reg, fadd_res;
    logic              mode_reg;
    logic [CNT_W-1:0]  op_count_reg;
    logic [NREQ-1:0]   ready_vec, rsp_vec;
    logic [31:0]       a_arr [NREQ];
    logic [31:0]       b_arr [NREQ];

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
        assign a_arr[gi] = bus.req_a[gi*32 +: 32];
        assign b_arr[gi] = bus.req_b[gi*32 +: 32];
    end

    rr_pick #(
        .NREQ  (NREQ),
        .PTR_W (PTR_W)
    ) u_pick (
        .valid     (bus.req_valid),
        .ptr       (ptr_reg),
        .grant     (grant),
        .any_valid (any_valid)
    );

    fadd32 u_fadd (
        .a    (a_reg),
        .b    (b_reg),
        .mode (mode_reg),
        .res  (fadd_res)
    );

    // The granted requester goes to the back of the queue
    assign ptr_inc = (grant == PTR_W'(NREQ - 1)) ? '0 : grant + PTR_W'(1);

    // Next state plus grant/response strobes
    always_comb begin
        state_next = state_reg;
        ready_vec  = '0;
        rsp_vec    = '0;
        accept     = 1'b0;
        take       = 1'b0;
        case (state_reg)
            S_IDLE: begin
                if (any_valid) begin
                    ready_vec[grant] = 1'b1;
                    accept           = 1'b1;
                    state_next       = S_EXEC;
                end
            end
            S_EXEC: begin
                state_next = S_RESP;
            end
            S_RESP: begin
                rsp_vec[owner_reg] = 1'b1;
                if (bus.rsp_ready[owner_reg]) begin
                    take       = 1'b1;
                    state_next = S_IDLE;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // State, operand capture, result register and completion counter
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg    <= S_IDLE;
            ptr_reg      <= '0;
            owner_reg    <= '0;
            a_reg        <= '0;
            b_reg        <= '0;
            mode_reg     <= FADD_MODE_ADD;
            res_reg      <= '0;
            op_count_reg <= '0;
        end else begin
            state_reg <= state_next;
            if (accept) begin
                a_reg     <= a_arr[grant];
                b_reg     <= b_arr[grant];
                mode_reg  <= bus.req_mode[grant];
                owner_reg <= grant;
                ptr_reg   <= ptr_inc;
            end
            if (state_reg == S_EXEC) begin
                res_reg <= fadd_res;
            end
            if (take) begin
                op_count_reg <= op_count_reg + CNT_W'(1);
            end
        end
    end

    assign bus.req_ready = ready_vec;
    assign bus.rsp_valid = rsp_vec;
    assign bus.rsp_res   = res_reg;
    assign busy          = (state_reg != S_IDLE);
    assign op_count      = op_count_reg;

endmodule
